// File: rtl/huffman_pkg.sv
// Shared definitions for the canonical Huffman blocks (decoder and tree builder).
// HUFF_DEC_ERR_EN adds the ERROR state to the decoder state enum.
package huffman_pkg;

  localparam int HUFF_MAX_LEN   = 16;
  localparam int HUFF_SYM_WIDTH = 8;
  localparam int HUFF_NUM_SYMS  = 256;
  localparam int HUFF_LEN_W     = $clog2(HUFF_MAX_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_DRAIN  = 2'd2
`ifdef HUFF_DEC_ERR_EN
    , ST_ERROR = 2'd3
`endif
  } hd_state_t;

  // bits needed to hold a code length 0..max_len
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // bits needed to hold a symbol index 0..num_syms (inclusive)
  function automatic int idx_w(input int num_syms);
    return $clog2(num_syms) + 1;
  endfunction

endpackage

// File: rtl/huffman_code_table.sv
// Canonical code description: per-length code counts plus the symbol list in
// code order. Both arrays have asynchronous read ports for the decoder.
// Counts reset to zero; the symbol RAM is not reset.
module huffman_code_table
  import huffman_pkg::*;
#(
  parameter int SYM_WIDTH = HUFF_SYM_WIDTH,
  parameter int NUM_SYMS  = HUFF_NUM_SYMS,
  parameter int MAX_LEN   = HUFF_MAX_LEN
) (
  input  logic                          clk,
  input  logic                          rst_n_in,
  input  logic                          len_we_in,
  input  logic [$clog2(MAX_LEN+1)-1:0]  len_addr_in,
  input  logic [$clog2(NUM_SYMS):0]     len_cnt_in,
  input  logic                          sym_we_in,
  input  logic [$clog2(NUM_SYMS)-1:0]   sym_addr_in,
  input  logic [SYM_WIDTH-1:0]          sym_val_in,
  input  logic [$clog2(MAX_LEN+1)-1:0]  cnt_rd_addr_in,
  output logic [$clog2(NUM_SYMS):0]     cnt_rd_out,
  input  logic [$clog2(NUM_SYMS)-1:0]   sym_rd_addr_in,
  output logic [SYM_WIDTH-1:0]          sym_rd_out
);

  localparam int LW    = len_w(MAX_LEN);
  localparam int IW    = idx_w(NUM_SYMS);
  localparam int DEPTH = 1 << LW;

  // Indexed directly by code length; slot 0 and slots above MAX_LEN are
  // never read by the decoder, so no address qualification is needed.
  logic [IW-1:0]        cnt_q   [DEPTH];
  logic [SYM_WIDTH-1:0] sym_mem [NUM_SYMS];

  // count array: cleared on reset so an unloaded table matches nothing
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
    end else if (len_we_in) begin
      cnt_q[len_addr_in] <= len_cnt_in;
    end
  end

  // symbol RAM write port
  always_ff @(posedge clk) begin
    if (sym_we_in) sym_mem[sym_addr_in] <= sym_val_in;
  end

  assign cnt_rd_out = cnt_q[cnt_rd_addr_in];
  assign sym_rd_out = sym_mem[sym_rd_addr_in];

endmodule

// File: rtl/huffman_decoder.sv
// Canonical Huffman bitstream decoder: one bit per cycle in, one symbol per
// valid/ready handshake out.
// HUFF_DEC_ERR_EN: enables overlong-code / table-overrun detection, the ERROR
// state and the sticky error_out flag. Without it error_out is tied low and an
// unmatched MAX_LEN code is silently dropped.
module huffman_decoder
  import huffman_pkg::*;
#(
  parameter int SYM_WIDTH = HUFF_SYM_WIDTH,
  parameter int NUM_SYMS  = HUFF_NUM_SYMS,
  parameter int MAX_LEN   = HUFF_MAX_LEN,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n_in,
  input  logic                          len_we_in,
  input  logic [$clog2(MAX_LEN+1)-1:0]  len_addr_in,
  input  logic [$clog2(NUM_SYMS):0]     len_cnt_in,
  input  logic                          sym_we_in,
  input  logic [$clog2(NUM_SYMS)-1:0]   sym_addr_in,
  input  logic [SYM_WIDTH-1:0]          sym_val_in,
  input  logic                          start_in,
  input  logic [CNT_WIDTH-1:0]          num_syms_in,
  input  logic                          bit_valid_in,
  input  logic                          bit_in,
  output logic                          bit_ready_out,
  output logic                          sym_valid_out,
  output logic [SYM_WIDTH-1:0]          sym_out,
  input  logic                          sym_ready_in,
  output logic                          busy_out,
  output logic                          done_out,
  output logic                          error_out
);

  localparam int LW = len_w(MAX_LEN);
  localparam int IW = idx_w(NUM_SYMS);
  localparam int AW = $clog2(NUM_SYMS);
  localparam int CW = MAX_LEN + 1;
  // wide enough that first+cnt and index+offset never wrap
  localparam int XW = CW + IW + 1;
  localparam logic [LW-1:0] LEN_LAST = LW'(MAX_LEN);

  hd_state_t            state;
  logic [CW-1:0]        code_q, first_q;
  logic [IW-1:0]        index_q;
  logic [LW-1:0]        len_q;
  logic [CNT_WIDTH-1:0] remain_q;
  logic                 sym_valid_q;
  logic [SYM_WIDTH-1:0] sym_q;
  logic                 done_q;

  logic [LW-1:0]        len_nxt;
  logic [CW-1:0]        code_nxt;
  logic [IW-1:0]        cnt_rd;
  logic [AW-1:0]        sym_rd_addr;
  logic [SYM_WIDTH-1:0] sym_rd;
  logic [XW-1:0]        code_x, first_x, lim_x;
  logic                 hit, at_max, bit_acc, idle;

  assign idle = (state == ST_IDLE);

  huffman_code_table #(
    .SYM_WIDTH (SYM_WIDTH),
    .NUM_SYMS  (NUM_SYMS),
    .MAX_LEN   (MAX_LEN)
  ) u_tbl (
    .clk            (clk),
    .rst_n_in       (rst_n_in),
    .len_we_in      (len_we_in && idle),
    .len_addr_in    (len_addr_in),
    .len_cnt_in     (len_cnt_in),
    .sym_we_in      (sym_we_in && idle),
    .sym_addr_in    (sym_addr_in),
    .sym_val_in     (sym_val_in),
    .cnt_rd_addr_in (len_nxt),
    .cnt_rd_out     (cnt_rd),
    .sym_rd_addr_in (sym_rd_addr),
    .sym_rd_out     (sym_rd)
  );

  // Decode step for the bit currently presented
  assign len_nxt     = len_q + 1'b1;
  assign code_nxt    = {code_q[CW-2:0], bit_in};
  assign code_x      = XW'(code_nxt);
  assign first_x     = XW'(first_q);
  assign lim_x       = first_x + XW'(cnt_rd);
  assign hit         = code_x < lim_x;
  assign at_max      = (len_nxt == LEN_LAST);
  assign sym_rd_addr = AW'(XW'(index_q) + code_x - first_x);

`ifdef HUFF_DEC_ERR_EN
  logic err_q;
  logic overrun;
  assign overrun   = (XW'(index_q) + code_x - first_x) >= XW'(NUM_SYMS);
  assign error_out = err_q;
`else
  assign error_out = 1'b0;
`endif

  // A bit may enter while the held symbol is being popped in the same cycle
  assign bit_ready_out = (state == ST_DECODE) && (!sym_valid_q || sym_ready_in);
  assign bit_acc       = bit_valid_in && bit_ready_out;
  assign sym_valid_out = sym_valid_q;
  assign sym_out       = sym_q;
  assign busy_out      = !idle;
  assign done_out      = done_q;

  // Decoder FSM with per-code state and the output symbol register
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= ST_IDLE;
      code_q      <= '0;
      first_q     <= '0;
      index_q     <= '0;
      len_q       <= '0;
      remain_q    <= '0;
      sym_valid_q <= 1'b0;
      sym_q       <= '0;
      done_q      <= 1'b0;
`ifdef HUFF_DEC_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_in) begin
            code_q  <= '0;
            first_q <= '0;
            index_q <= '0;
            len_q   <= '0;
            if (num_syms_in == '0) begin
              done_q <= 1'b1;
            end else begin
              remain_q <= num_syms_in;
              state    <= ST_DECODE;
            end
          end
        end
        ST_DECODE: begin
          if (sym_valid_q && sym_ready_in) sym_valid_q <= 1'b0;
          if (bit_acc) begin
`ifdef HUFF_DEC_ERR_EN
            if ((hit && overrun) || (!hit && at_max)) begin
              err_q <= 1'b1;
              state <= ST_ERROR;
            end else
`endif
            if (hit) begin
              sym_q       <= sym_rd;
              sym_valid_q <= 1'b1;
              code_q      <= '0;
              first_q     <= '0;
              index_q     <= '0;
              len_q       <= '0;
              remain_q    <= remain_q - 1'b1;
              if (remain_q == CNT_WIDTH'(1)) state <= ST_DRAIN;
            end else if (at_max) begin
              // unmatched full-length code: drop it and resync on next bit
              code_q  <= '0;
              first_q <= '0;
              index_q <= '0;
              len_q   <= '0;
            end else begin
              len_q   <= len_nxt;
              code_q  <= code_nxt;
              first_q <= CW'(lim_x << 1);
              index_q <= index_q + cnt_rd;
            end
          end
        end
        ST_DRAIN: begin
          if (sym_ready_in) begin
            sym_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state       <= ST_IDLE;
          end
        end
`ifdef HUFF_DEC_ERR_EN
        ST_ERROR: begin
          if (sym_valid_q && sym_ready_in) sym_valid_q <= 1'b0;
          if (start_in) begin
            err_q       <= 1'b0;
            sym_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder (MAX_LEN=3 build). Expected symbols
// and their appearance cycle are queued as the final bit of each code is
// driven, and checked when the output shows/pops them.
module tb_huffman_decoder;

  localparam int SW   = 8;
  localparam int NS   = 256;
  localparam int ML   = 3;
  localparam int CNTW = 16;

  logic          clk = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          len_we_in = 1'b0;
  logic [1:0]    len_addr_in = '0;
  logic [8:0]    len_cnt_in = '0;
  logic          sym_we_in = 1'b0;
  logic [7:0]    sym_addr_in = '0;
  logic [SW-1:0] sym_val_in = '0;
  logic          start_in = 1'b0;
  logic [CNTW-1:0] num_syms_in = '0;
  logic          bit_valid_in = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_ready_out;
  logic          sym_valid_out;
  logic [SW-1:0] sym_out;
  logic          sym_ready_in = 1'b1;
  logic          busy_out, done_out, error_out;

  huffman_decoder #(
    .SYM_WIDTH (SW),
    .NUM_SYMS  (NS),
    .MAX_LEN   (ML),
    .CNT_WIDTH (CNTW)
  ) dut (
    .clk           (clk),
    .rst_n_in      (rst_n_in),
    .len_we_in     (len_we_in),
    .len_addr_in   (len_addr_in),
    .len_cnt_in    (len_cnt_in),
    .sym_we_in     (sym_we_in),
    .sym_addr_in   (sym_addr_in),
    .sym_val_in    (sym_val_in),
    .start_in      (start_in),
    .num_syms_in   (num_syms_in),
    .bit_valid_in  (bit_valid_in),
    .bit_in        (bit_in),
    .bit_ready_out (bit_ready_out),
    .sym_valid_out (sym_valid_out),
    .sym_out       (sym_out),
    .sym_ready_in  (sym_ready_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .error_out     (error_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] sym; int cyc; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int stall_cnt = 0, held = 0, hold = 0;
  int done_cnt = 0, done_cyc = -1, last_pop_cyc = -1;
  bit bp_arm = 0, busy_seen = 0;
  bit prev_valid = 0, prev_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Output side: drives sym_ready_in (with optional backpressure) and
  // scores every symbol against the queue.
  always begin
    @(negedge clk);
    if (hold > 0) begin
      sym_ready_in = 1'b0; hold--; held++;
    end else if (bp_arm && sym_valid_out && sym_out == 8'h42) begin
      bp_arm = 0; hold = 4; held++; sym_ready_in = 1'b0;
    end else begin
      sym_ready_in = 1'b1;
    end
    #2;
    if (!rst_n_in) begin
      prev_valid = 0; prev_pop = 0;
    end else begin
      if (busy_out) busy_seen = 1;
      if (done_out) begin done_cnt++; done_cyc = cyc; end
      if (sym_valid_out && !sym_ready_in) chk("bp_bit_ready", 32'(bit_ready_out), 32'd0);
      if (sym_valid_out && (!prev_valid || prev_pop)) begin
        if (exp_q.size() == 0) chk("sym_extra", 32'(sym_out), 32'hFFFF);
        else begin
          chk("sym_val", 32'(sym_out), 32'(exp_q[0].sym));
          chk("sym_lat", 32'(cyc), 32'(exp_q[0].cyc));
        end
      end
      prev_pop = sym_valid_out && sym_ready_in;
      if (prev_pop && exp_q.size() > 0) begin
        chk("sym_pop", 32'(sym_out), 32'(exp_q[0].sym));
        void'(exp_q.pop_front());
        last_pop_cyc = cyc;
      end
      prev_valid = sym_valid_out;
    end
  end

  task automatic load_tbl(input logic [8:0] c1, input logic [8:0] c2, input logic [8:0] c3);
    logic [8:0] cs [3];
    cs[0] = c1; cs[1] = c2; cs[2] = c3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); len_we_in = 1'b1; len_addr_in = 2'(i + 1); len_cnt_in = cs[i];
    end
    @(negedge clk); len_we_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); sym_we_in = 1'b1; sym_addr_in = 8'(i); sym_val_in = 8'(8'h41 + i);
    end
    @(negedge clk); sym_we_in = 1'b0;
  endtask

  task automatic start(input logic [CNTW-1:0] n);
    @(negedge clk); start_in = 1'b1; num_syms_in = n;
    @(negedge clk); start_in = 1'b0;
  endtask

  // Presents one bit; when it ends a code, queues the symbol and the cycle it
  // must appear on the output.
  task automatic send_bit(input logic b, input bit last, input logic [7:0] sym);
    int w = 0;
    exp_t e;
    @(negedge clk); bit_valid_in = 1'b1; bit_in = b; #1;
    while (!bit_ready_out && w < 50) begin
      @(negedge clk); #1; w++; stall_cnt++;
    end
    chk("bit_accept", 32'(bit_ready_out), 32'd1);
    if (last) begin
      e.sym = sym; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic stop_bits();
    @(negedge clk); bit_valid_in = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  task automatic send_abcd();
    send_bit(1'b0, 1, 8'h41);
    send_bit(1'b1, 0, 8'h00); send_bit(1'b0, 1, 8'h42);
    send_bit(1'b1, 0, 8'h00); send_bit(1'b1, 0, 8'h00); send_bit(1'b0, 1, 8'h43);
    send_bit(1'b1, 0, 8'h00); send_bit(1'b1, 0, 8'h00); send_bit(1'b1, 1, 8'h44);
    stop_bits();
  endtask

  task automatic chk_reset_vals();
    chk("rst_bit_ready", 32'(bit_ready_out), 32'd0);
    chk("rst_sym_valid", 32'(sym_valid_out), 32'd0);
    chk("rst_sym_out",   32'(sym_out),       32'd0);
    chk("rst_busy",      32'(busy_out),      32'd0);
    chk("rst_done",      32'(done_out),      32'd0);
    chk("rst_error",     32'(error_out),     32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    #1 chk_reset_vals();
    rst_n_in = 1'b1;
    load_tbl(9'd1, 9'd1, 9'd2);

    // basic continuous decode
    stall_cnt = 0; done_cnt = 0;
    start(16'd4);
    send_abcd();
    settle(6);
    chk("basic_bubbles", 32'(stall_cnt), 32'd0);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    chk("basic_done_lat", 32'(done_cyc), 32'(last_pop_cyc + 1));
    chk("basic_q_empty", 32'(exp_q.size()), 32'd0);

    // backpressure: hold 0x42 for 5 cycles
    stall_cnt = 0; done_cnt = 0; held = 0; bp_arm = 1;
    start(16'd4);
    send_abcd();
    settle(6);
    chk("bp_held", 32'(held), 32'd5);
    chk("bp_stalls", 32'(stall_cnt), 32'd5);
    chk("bp_done_cnt", 32'(done_cnt), 32'd1);
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // zero-length job
    busy_seen = 0; done_cnt = 0;
    @(negedge clk); start_in = 1'b1; num_syms_in = '0; c = cyc;
    @(negedge clk); start_in = 1'b0;
    settle(3);
    chk("zero_done_cnt", 32'(done_cnt), 32'd1);
    chk("zero_done_lat", 32'(done_cyc), 32'(c + 1));
    chk("zero_busy", 32'(busy_seen), 32'd0);

    // overlong code: only a single length-3 code (000) exists
    load_tbl(9'd0, 9'd0, 9'd1);
    done_cnt = 0;
    start(16'd1);
    send_bit(1'b1, 0, 8'h00); send_bit(1'b1, 0, 8'h00); send_bit(1'b1, 0, 8'h00);
`ifdef HUFF_DEC_ERR_EN
    stop_bits(); #1;
    chk("err_flag", 32'(error_out), 32'd1);
    chk("err_bit_ready", 32'(bit_ready_out), 32'd0);
    chk("err_busy", 32'(busy_out), 32'd1);
    start(16'd0);
    #1;
    chk("err_cleared", 32'(error_out), 32'd0);
    chk("err_idle", 32'(busy_out), 32'd0);
`else
    send_bit(1'b0, 0, 8'h00); send_bit(1'b0, 0, 8'h00); send_bit(1'b0, 1, 8'h41);
    stop_bits();
    settle(4);
    chk("noerr_flag", 32'(error_out), 32'd0);
    chk("noerr_done", 32'(done_cnt), 32'd1);
    chk("noerr_q_empty", 32'(exp_q.size()), 32'd0);
`endif

    // reset mid-code, then restart
    load_tbl(9'd1, 9'd1, 9'd2);
    start(16'd4);
    send_bit(1'b1, 0, 8'h00); send_bit(1'b1, 0, 8'h00);
    @(negedge clk); bit_valid_in = 1'b0; rst_n_in = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk); rst_n_in = 1'b1;
    load_tbl(9'd1, 9'd1, 9'd2);
    done_cnt = 0;
    start(16'd1);
    send_bit(1'b0, 1, 8'h41);
    stop_bits();
    settle(4);
    chk("rst_restart_done", 32'(done_cnt), 32'd1);
    chk("rst_restart_q", 32'(exp_q.size()), 32'd0);

    // table write during DECODE must be ignored
    done_cnt = 0;
    start(16'd1);
    @(negedge clk); len_we_in = 1'b1; len_addr_in = 2'd1; len_cnt_in = 9'd0;
    @(negedge clk); len_we_in = 1'b0;
    send_bit(1'b0, 1, 8'h41);
    stop_bits();
    settle(4);
    chk("busy_wr_done", 32'(done_cnt), 32'd1);
    chk("busy_wr_q", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
